adxl362_fifo: RTL and testbench
===============================

ADXL362_FIFO -- requirements
Module: adxl362_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 512: number of 16-bit FIFO entries.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9: log2(DEPTH).
REQ-003 SHALL have port clk_16mhz, input, 1: the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port fifo_write, input, 1: one-cycle write strobe from the accelerometer sample engine.
REQ-006 SHALL have port fifo_write_data, input, 16: [15:14] axis tag (00 X, 01 Y, 10 Z, 11 temperature), [13:0] sign-extended sample.
REQ-007 SHALL have port fifo_mode, input, 2: 00 disabled, 01 oldest-saved, 10 stream, 11 triggered.
REQ-008 SHALL have port fifo_samples, input, ADDR_WIDTH: watermark level and pre-trigger depth.
REQ-009 SHALL have port trigger, input, 1: trigger event, level-sampled.
REQ-010 SHALL have port fifo_read, input, 1: one-cycle read strobe.
REQ-011 SHALL have port fifo_read_data, output, 16: registered head entry.
REQ-012 SHALL have port fifo_entries, output, ADDR_WIDTH+1: current occupancy, 0..DEPTH.
REQ-013 SHALL have ports fifo_empty, fifo_full, fifo_watermark and fifo_overrun, each output, 1.
REQ-014 SHALL have port fifo_max_entries, output, ADDR_WIDTH+1: peak occupancy.

Function
REQ-015 SHALL implement FSM states DISABLED, ACTIVE, TRIG_ARMED and TRIG_CAPTURE.
REQ-016 SHALL move the FSM as follows: mode 00 -> DISABLED; mode 01/10 -> ACTIVE; mode 11 -> TRIG_ARMED; TRIG_ARMED -> TRIG_CAPTURE on trigger=1; TRIG_CAPTURE holds until a mode change.
REQ-017 SHALL, when fifo_mode differs from its previous-cycle value, flush in that cycle: pointers=0, entries=0, fifo_overrun=0, and writes/reads that cycle ignored.
REQ-018 SHALL, in DISABLED, hold the FIFO flushed and ignore fifo_write and fifo_read.
REQ-019 SHALL, on an accepted write, store the entry at the write pointer, with pointers wrapping modulo DEPTH.
REQ-020 SHALL, in mode 01 when full, drop the incoming write and set fifo_overrun.
REQ-021 SHALL, in mode 10 when full, advance the read pointer, store the incoming write, keep entries=DEPTH and set fifo_overrun.
REQ-022 SHALL, in TRIG_ARMED, behave as stream mode with capacity capped at fifo_samples (entries never exceed fifo_samples, oldest dropped, no overrun).
REQ-023 SHALL, in TRIG_CAPTURE, behave as oldest-saved.
REQ-024 SHALL, on fifo_read while not empty, present the head entry on fifo_read_data at the next cycle, with entries decremented in that same cycle.
REQ-025 SHALL, on fifo_read while empty, leave fifo_read_data and entries unchanged.
REQ-026 SHALL, on simultaneous accepted read and write, leave entries unchanged; when full, both proceed and no overrun occurs.
REQ-027 SHALL drive fifo_watermark = (fifo_samples != 0) && (entries >= fifo_samples).
REQ-028 SHALL drive fifo_empty = (entries==0) and fifo_full = (entries==DEPTH).
REQ-029 SHALL keep fifo_overrun sticky until a flush or reset.

Reset
REQ-030 SHALL, on reset=1, set FSM=DISABLED, pointers=0, fifo_entries=0, fifo_read_data=0, fifo_overrun=0, fifo_watermark=0, fifo_full=0, fifo_empty=1, fifo_max_entries=0, and previous mode=00.
REQ-031 SHALL give reset priority over all writes, reads and flushes, including mid-capture.

Configuration
REQ-032 SHALL, with ADXL362_FIFO_PEAK_EN defined, make fifo_max_entries track the maximum entries since the last reset or flush, updated one cycle after entries changes.
REQ-033 SHALL, without ADXL362_FIFO_PEAK_EN, tie fifo_max_entries to 0 and synthesize no peak logic.

Structure
REQ-034 SHALL place the mode encodings, FSM state encodings, tag encodings and DEPTH default in shared package adxl362_pkg.
REQ-035 SHALL implement storage in sub-module adxl362_fifo_ram: simple dual-port, DEPTH x 16, synchronous read.

Verification
REQ-036 SHALL verify: mode 01, write 0x0123,0x4456,0x8789 then three reads -> the same values in order, one cycle after each read; entries 3->0, empty=1.
REQ-037 SHALL verify: mode 01, 513 writes -> entries=512, full=1, overrun=1, head entry = first write.
REQ-038 SHALL verify: mode 10, 514 writes of values 0..513 -> entries=512, overrun=1, first read returns 2.
REQ-039 SHALL verify: mode 11, fifo_samples=8, 20 writes, trigger, 600 further writes -> the first 8 reads equal writes 12..19, entries reaches 512 and overrun=1.
REQ-040 SHALL verify: fifo_samples=4, 4 writes -> watermark=1; a read -> watermark=0; a read while empty -> data unchanged.
REQ-041 SHALL verify: reset asserted mid-stream at entries=100 -> all outputs at reset values the next cycle; fifo_max_entries=100 before the reset with ADXL362_FIFO_PEAK_EN defined, 0 without it.

Source files
------------

// File: rtl/adxl362_pkg.sv
// adxl362_pkg: shared mode, FSM state and axis-tag encodings plus FIFO size defaults
package adxl362_pkg;
    localparam int DEPTH_DEFAULT = 512;
    localparam int ADDR_WIDTH_DEFAULT = 9;
    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_OLDEST = 2'b01,
        MODE_STREAM = 2'b10,
        MODE_TRIG   = 2'b11
    } fifo_mode_t;
    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_ACTIVE,
        ST_TRIG_ARMED,
        ST_TRIG_CAPTURE
    } fifo_state_t;
    typedef enum logic [1:0] {
        TAG_X    = 2'b00,
        TAG_Y    = 2'b01,
        TAG_Z    = 2'b10,
        TAG_TEMP = 2'b11
    } axis_tag_t;
endpackage

// File: rtl/adxl362_fifo_ram.sv
// adxl362_fifo_ram: simple dual-port DEPTH x 16 storage, read-first, synchronous read with hold
module adxl362_fifo_ram import adxl362_pkg::*; #(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [15:0]           wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [15:0]           rdata
);
    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // rdata only moves on an accepted read so an empty-FIFO read leaves it intact
    always_ff @(posedge clk)
        if (reset) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/adxl362_fifo.sv
// adxl362_fifo: ADXL362-style sample FIFO with oldest-saved, stream and triggered modes.
// Define ADXL362_FIFO_PEAK_EN to enable the fifo_max_entries peak-occupancy tracker.
module adxl362_fifo import adxl362_pkg::*; #(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk_16mhz,
    input  logic                  reset,
    input  logic                  fifo_write,
    input  logic [15:0]           fifo_write_data,
    input  logic [1:0]            fifo_mode,
    input  logic [ADDR_WIDTH-1:0] fifo_samples,
    input  logic                  trigger,
    input  logic                  fifo_read,
    output logic [15:0]           fifo_read_data,
    output logic [ADDR_WIDTH:0]   fifo_entries,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  fifo_watermark,
    output logic                  fifo_overrun,
    output logic [ADDR_WIDTH:0]   fifo_max_entries
);
    localparam logic [ADDR_WIDTH:0] full_lvl = (ADDR_WIDTH+1)'(DEPTH);

    fifo_state_t state, state_nxt;
    logic [1:0] prev_mode;
    logic flush, active, capped, overwrite;
    logic rd_ok, blocked, evict, wr_ok, ovr_set;
    logic [ADDR_WIDTH:0] cnt, cap;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;

    assign flush = fifo_mode != prev_mode;

    always_ff @(posedge clk_16mhz) begin
        state <= reset ? ST_DISABLED : state_nxt;
        prev_mode <= reset ? 2'b00 : fifo_mode;
    end

    always_comb
        state_nxt = fifo_mode == MODE_OFF ? ST_DISABLED :
                    fifo_mode != MODE_TRIG ? ST_ACTIVE :
                    (flush || !(state inside {ST_TRIG_ARMED, ST_TRIG_CAPTURE})) ? ST_TRIG_ARMED :
                    (state == ST_TRIG_ARMED && trigger) ? ST_TRIG_CAPTURE : state;

    // While armed the FIFO is a stream buffer whose capacity is the pre-trigger depth
    always_comb begin
        active = state != ST_DISABLED && !flush;
        capped = state == ST_TRIG_ARMED;
        overwrite = capped || (state == ST_ACTIVE && fifo_mode == MODE_STREAM);
        cap = capped ? {1'b0, fifo_samples} : full_lvl;
    end

    always_comb begin
        rd_ok = active && fifo_read && cnt != '0;
        blocked = active && fifo_write && cnt >= cap && !rd_ok;
        evict = blocked && overwrite && cap != '0;
        wr_ok = active && fifo_write && (!blocked || evict);
        ovr_set = blocked && !capped;
    end

    always_ff @(posedge clk_16mhz) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
            fifo_overrun <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (rd_ok || evict) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            cnt <= (wr_ok && !evict && !rd_ok) ? cnt + (ADDR_WIDTH+1)'(1) :
                   (rd_ok && !wr_ok) ? cnt - (ADDR_WIDTH+1)'(1) : cnt;
            fifo_overrun <= fifo_overrun | ovr_set;
        end
    end

    adxl362_fifo_ram #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk(clk_16mhz),
        .reset(reset),
        .we(wr_ok),
        .waddr(wr_ptr),
        .wdata(fifo_write_data),
        .re(rd_ok),
        .raddr(rd_ptr),
        .rdata(fifo_read_data)
    );

    assign fifo_entries = cnt;
    assign fifo_empty = cnt == '0;
    assign fifo_full = cnt == full_lvl;
    assign fifo_watermark = fifo_samples != '0 && cnt >= {1'b0, fifo_samples};

`ifdef ADXL362_FIFO_PEAK_EN
    logic [ADDR_WIDTH:0] peak;

    always_ff @(posedge clk_16mhz)
        if (reset || flush) peak <= '0;
        else if (cnt > peak) peak <= cnt;

    assign fifo_max_entries = peak;
`else
    assign fifo_max_entries = '0;
`endif
endmodule

// File: tb/tb_adxl362_fifo.sv
// tb_adxl362_fifo: directed and randomized checks of adxl362_fifo against a queue-based model.
module tb_adxl362_fifo;
    logic        clk_16mhz = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_write = 1'b0;
    logic [15:0] fifo_write_data = '0;
    logic [1:0]  fifo_mode = 2'b00;
    logic [8:0]  fifo_samples = '0;
    logic        trigger = 1'b0;
    logic        fifo_read = 1'b0;
    logic [15:0] fifo_read_data;
    logic [9:0]  fifo_entries;
    logic        fifo_empty, fifo_full, fifo_watermark, fifo_overrun;
    logic [9:0]  fifo_max_entries;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] q[$];
    bit          m_ovr = 0;
    logic [15:0] m_rd = '0;
    bit          m_trg = 0;
    logic [1:0]  m_prev = 2'b00;
    int          m_peak = 0;

    adxl362_fifo dut (
        .clk_16mhz(clk_16mhz),
        .reset(reset),
        .fifo_write(fifo_write),
        .fifo_write_data(fifo_write_data),
        .fifo_mode(fifo_mode),
        .fifo_samples(fifo_samples),
        .trigger(trigger),
        .fifo_read(fifo_read),
        .fifo_read_data(fifo_read_data),
        .fifo_entries(fifo_entries),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full),
        .fifo_watermark(fifo_watermark),
        .fifo_overrun(fifo_overrun),
        .fifo_max_entries(fifo_max_entries)
    );

    always #5 clk_16mhz = ~clk_16mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Spec-level behaviour of one clock edge, from the inputs present at that edge
    task automatic model_edge();
        int sz;
        int lim;
        bit armed, ow, rd;
        sz = q.size();
        if (reset) begin
            q.delete(); m_ovr = 0; m_rd = '0; m_trg = 0; m_prev = 2'b00; m_peak = 0;
            return;
        end
        if (fifo_mode != m_prev) begin
            q.delete(); m_ovr = 0; m_trg = 0; m_prev = fifo_mode; m_peak = 0;
            return;
        end
        if (sz > m_peak) m_peak = sz;
        if (fifo_mode == 2'b00) return;
        armed = fifo_mode == 2'b11 && !m_trg;
        lim = armed ? int'(fifo_samples) : 512;
        ow = fifo_mode == 2'b10 || armed;
        rd = fifo_read && sz > 0;
        if (rd) m_rd = q.pop_front();
        if (fifo_write) begin
            if (rd || sz < lim) q.push_back(fifo_write_data);
            else if (ow && lim != 0) begin
                void'(q.pop_front());
                q.push_back(fifo_write_data);
                if (fifo_mode == 2'b10) m_ovr = 1;
            end else if (!ow) m_ovr = 1;
        end
        if (armed && trigger) m_trg = 1;
    endtask

    task automatic check_all();
        chk("entries", fifo_entries, q.size());
        chk("empty", fifo_empty, q.size() == 0);
        chk("full", fifo_full, q.size() == 512);
        chk("watermark", fifo_watermark, fifo_samples != 0 && q.size() >= int'(fifo_samples));
        chk("overrun", fifo_overrun, m_ovr);
        chk("read_data", fifo_read_data, m_rd);
`ifdef ADXL362_FIFO_PEAK_EN
        chk("max_entries", fifo_max_entries, m_peak);
`else
        chk("max_entries", fifo_max_entries, 0);
`endif
    endtask

    task automatic step(input bit wr, input logic [15:0] d, input bit rd, input bit trg = 1'b0);
        fifo_write = wr;
        fifo_write_data = d;
        fifo_read = rd;
        trigger = trg;
        @(posedge clk_16mhz);
        model_edge();
        #1;
        fifo_write = 1'b0;
        fifo_read = 1'b0;
        trigger = 1'b0;
        check_all();
    endtask

    initial begin
        logic [15:0] held;
        int wb, rb;
        #1;
        step(0, '0, 0);
        chk("rst_entries", fifo_entries, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_data", fifo_read_data, 0);
        reset = 1'b0;

        fifo_mode = 2'b01;
        step(0, '0, 0);
        step(1, 16'h0123, 0);
        step(1, 16'h4456, 0);
        step(1, 16'h8789, 0);
        chk("seq_entries3", fifo_entries, 3);
        step(0, '0, 1);
        chk("seq_rd0", fifo_read_data, 16'h0123);
        step(0, '0, 1);
        chk("seq_rd1", fifo_read_data, 16'h4456);
        step(0, '0, 1);
        chk("seq_rd2", fifo_read_data, 16'h8789);
        chk("seq_entries0", fifo_entries, 0);
        chk("seq_empty", fifo_empty, 1);

        fifo_mode = 2'b00;
        step(0, '0, 0);
        fifo_mode = 2'b01;
        step(0, '0, 0);
        for (int i = 0; i < 513; i++) step(1, 16'h1000 + 16'(i), 0);
        chk("old_entries", fifo_entries, 512);
        chk("old_full", fifo_full, 1);
        chk("old_overrun", fifo_overrun, 1);
        step(0, '0, 1);
        chk("old_head", fifo_read_data, 16'h1000);

        fifo_mode = 2'b10;
        step(0, '0, 0);
        chk("flush_overrun", fifo_overrun, 0);
        for (int i = 0; i < 514; i++) step(1, 16'(i), 0);
        chk("str_entries", fifo_entries, 512);
        chk("str_overrun", fifo_overrun, 1);
        step(0, '0, 1);
        chk("str_head", fifo_read_data, 2);

        fifo_mode = 2'b11;
        fifo_samples = 9'd8;
        step(0, '0, 0);
        for (int i = 0; i < 20; i++) step(1, 16'(i), 0);
        chk("arm_entries", fifo_entries, 8);
        chk("arm_overrun", fifo_overrun, 0);
        step(0, '0, 0, 1);
        for (int i = 0; i < 600; i++) step(1, 16'h2000 + 16'(i), 0);
        chk("cap_entries", fifo_entries, 512);
        chk("cap_overrun", fifo_overrun, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, '0, 1);
            chk($sformatf("cap_rd%0d", i), fifo_read_data, 12 + i);
        end

        fifo_mode = 2'b01;
        fifo_samples = 9'd4;
        step(0, '0, 0);
        for (int i = 0; i < 4; i++) step(1, 16'h3000 + 16'(i), 0);
        chk("wm_set", fifo_watermark, 1);
        step(0, '0, 1);
        chk("wm_clr", fifo_watermark, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1);
        held = fifo_read_data;
        chk("drain_last", held, 16'h3003);
        step(0, '0, 1);
        chk("empty_rd_data", fifo_read_data, 16'h3003);
        chk("empty_rd_entries", fifo_entries, 0);

        fifo_mode = 2'b10;
        step(0, '0, 0);
        for (int i = 0; i < 100; i++) step(1, 16'h4000 + 16'(i), 0);
        step(0, '0, 0);
        chk("pre_rst_entries", fifo_entries, 100);
`ifdef ADXL362_FIFO_PEAK_EN
        chk("pre_rst_peak", fifo_max_entries, 100);
`else
        chk("pre_rst_peak", fifo_max_entries, 0);
`endif
        reset = 1'b1;
        step(1, 16'hffff, 1);
        chk("mid_rst_entries", fifo_entries, 0);
        chk("mid_rst_empty", fifo_empty, 1);
        chk("mid_rst_data", fifo_read_data, 0);
        chk("mid_rst_peak", fifo_max_entries, 0);
        chk("mid_rst_overrun", fifo_overrun, 0);
        reset = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(699) == 0) fifo_mode = 2'($urandom_range(3));
            if ($urandom_range(199) == 0) fifo_samples = 9'($urandom_range(15));
            reset = $urandom_range(1499) == 0;
            wb = ((i / 1000) % 2) != 0 ? 90 : 45;
            rb = ((i / 1000) % 2) != 0 ? 20 : 50;
            step($urandom_range(99) < wb, 16'($urandom), $urandom_range(99) < rb,
                 $urandom_range(59) == 0);
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
